// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared widths, operand-fetch output entry type and the
//               operand bypass selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREG  = 32;
    localparam int CTRLW = 16;

    typedef struct packed {
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [AW-1:0]    dr;
        logic             we;
        logic [CTRLW-1:0] ctrl;
    } of_entry_t;

    // r0 reads as zero; a same-cycle writeback to the source beats the bank,
    // which only updates at the clock edge.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [AW-1:0]   idx,
        input logic            wb_en,
        input logic [AW-1:0]   wb_dr,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rdata
    );
        if (idx == '0)
            return '0;
        else if (wb_en && (wb_dr == idx))
            return wb_data;
        else
            return rdata;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_scoreboard
// Description : Busy-bit register file tracking in-flight destinations.
//               Set on issue, cleared on writeback, cleared wholesale on
//               flush. eb hides a writeback landing this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_scoreboard
    import rv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            set_en,
    input  wire logic [AW-1:0]   set_idx,
    input  wire logic            clr_en,
    input  wire logic [AW-1:0]   clr_idx,
    input  wire logic            clr_all,
    output logic      [NREG-1:0] busy,
    output logic      [NREG-1:0] eb
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_busy_next;

    // Next busy state: clear first, then set, so a new owner wins a collision.
    always_comb begin
        w_clr_mask = '0;
        if (clr_en)
            w_clr_mask[clr_idx] = 1'b1;
        w_busy_next = r_busy & ~w_clr_mask;
        if (set_en)
            w_busy_next[set_idx] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // Busy register with synchronous clear on reset or flush.
    always_ff @(posedge clk) begin
        if (reset || clr_all)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign busy = r_busy;
    assign eb   = r_busy & ~w_clr_mask;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Issue / operand-fetch stage. Stalls on RAW/WAW hazards,
//               bypasses the same-cycle writeback and registers operands and
//               control into a single-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import rv_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [AW-1:0]    in_sr1,
    input  wire logic [AW-1:0]    in_sr2,
    input  wire logic [AW-1:0]    in_dr,
    input  wire logic             in_use1,
    input  wire logic             in_use2,
    input  wire logic             in_we,
    input  wire logic [CTRLW-1:0] in_ctrl,
    output logic      [AW-1:0]    rf_sr1,
    output logic      [AW-1:0]    rf_sr2,
    input  wire logic [XLEN-1:0]  rf_rdata1,
    input  wire logic [XLEN-1:0]  rf_rdata2,
    input  wire logic             wb_en,
    input  wire logic [AW-1:0]    wb_dr,
    input  wire logic [XLEN-1:0]  wb_data,
    input  wire logic             flush,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic      [XLEN-1:0]  out_op1,
    output logic      [XLEN-1:0]  out_op2,
    output logic      [AW-1:0]    out_dr,
    output logic                  out_we,
    output logic      [CTRLW-1:0] out_ctrl,
    output logic      [NREG-1:0]  busy
);

    logic [NREG-1:0] w_eb;
    logic            w_hazard;
    logic            w_space;
    logic            w_accept;
    of_entry_t       w_entry;
    of_entry_t       r_entry;
    logic            r_valid;

    operand_fetch_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (w_accept && in_we),
        .set_idx (in_dr),
        .clr_en  (wb_en),
        .clr_idx (wb_dr),
        .clr_all (flush),
        .busy    (busy),
        .eb      (w_eb)
    );

    assign rf_sr1 = in_sr1;
    assign rf_sr2 = in_sr2;

    // Hazard, handshake and bypassed operand selection for the offered instruction.
    always_comb begin
        w_hazard = (in_use1 && w_eb[in_sr1]) ||
                   (in_use2 && w_eb[in_sr2]) ||
                   (in_we   && w_eb[in_dr]);
        w_space  = !r_valid || out_ready;
        in_ready = !reset && !flush && !w_hazard && w_space;
        w_accept = in_valid && in_ready;

        w_entry.op1  = sel_operand(in_sr1, wb_en, wb_dr, wb_data, rf_rdata1);
        w_entry.op2  = sel_operand(in_sr2, wb_en, wb_dr, wb_data, rf_rdata2);
        w_entry.dr   = in_dr;
        w_entry.we   = in_we;
        w_entry.ctrl = in_ctrl;
    end

    // Single-entry output register: load on accept, drain on consume, squash on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_entry <= w_entry;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_op1   = r_entry.op1;
    assign out_op2   = r_entry.op2;
    assign out_dr    = r_entry.dr;
    assign out_we    = r_entry.we;
    assign out_ctrl  = r_entry.ctrl;

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
# operand_fetch

Issue/operand-fetch stage directly upstream of the register bank's read ports. It accepts decoded register specifiers through a valid/ready handshake and drives the bank read addresses. It holds back RAW/WAW hazards with a 32-entry busy-bit scoreboard and bypasses the same-cycle writeback value. Fetched operands and control are registered into a single-entry output pipeline register for the execute stage.

## Interface
- XLEN, 32, datapath width
- AW, 5, register index width (32 registers)
- CTRLW, 16, opaque control payload width passed to execute
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  stage accepts this cycle
- in_sr1, in_sr2, in_dr  in  AW  source/destination indices
- in_use1, in_use2  in  1  source operand actually read
- in_we  in  1  instruction writes in_dr
- in_ctrl  in  CTRLW  pass-through control
- rf_sr1, rf_sr2  out  AW  register bank read addresses (= in_sr1, in_sr2)
- rf_rdata1, rf_rdata2  in  XLEN  bank read data (combinational)
- wb_en, wb_dr, wb_data  in  1/AW/XLEN  writeback port, identical to the bank write port in the same cycle
- flush  in  1  squash the output entry and clear the scoreboard
- out_valid  out  1  registered entry valid
- out_ready  in  1  execute consumes entry
- out_op1, out_op2  out  XLEN  operands
- out_dr  out  AW, out_we out 1, out_ctrl out CTRLW  registered copies
- busy  out  32  scoreboard state, debug/verification

## Operation
- Scoreboard busy[31:0]. Bit 0 is hardwired 0.
- Issue sets busy[in_dr] when in_we and in_dr != 0. Writeback clears busy[wb_dr] when wb_en.
- Effective busy is eb = busy & ~(wb_en ? onehot(wb_dr) : 0), so a writeback landing this cycle resolves the hazard immediately.
- hazard = (in_use1 & eb[in_sr1]) | (in_use2 & eb[in_sr2]) | (in_we & eb[in_dr]). The last term is the WAW check.
- space = !out_valid | out_ready.
- in_ready = !reset & !flush & !hazard & space.
- accept = in_valid & in_ready.
- Operand select, per source s:
  - index 0 gives 0;
  - else if wb_en & wb_dr == index, gives wb_data (bypass; the bank updates only at the edge);
  - else gives rf_rdata.
- Unused operands (use = 0) are still captured; their values are don't-care.
- On accept, the output register loads the operands, in_dr, in_we and in_ctrl, and out_valid becomes 1.
- When out_ready is high and there is no accept, out_valid becomes 0.
- Simultaneous set and clear of the same index: set wins, because the new instruction owns the register.
- flush:
  - out_valid goes to 0 and busy goes to 0 next cycle;
  - no accept in that cycle;
  - the writeback in the flush cycle still updates the bank.
- Contract: downstream squashes its in-flight instructions on flush, and their writebacks never arrive.
- Reset: out_valid=0, busy=0, out_op1/out_op2/out_dr/out_we/out_ctrl=0. in_ready=0 while reset is high.

## Timing
- Read path is combinational: in_sr, then rf_sr, then rf_rdata, then the mux, then the output register. Latency is 1 cycle from accept to out_valid.
- Stalls are controlled by in_ready. in_valid/payload must stay stable until accepted.
- The output entry holds while out_valid & !out_ready. Back-to-back accept each cycle is possible when out_ready=1.
- Scoreboard updates at the posedge following the issue/writeback. An instruction dependent on one issued the previous cycle stalls until that writeback cycle; it is accepted in that cycle with the bypassed value.
- Reset or flush asserted mid-stall drops nothing upstream, because nothing was accepted.

## Structure
- Shared package rv_pkg: XLEN, AW, NREG=32, CTRLW, and an of_entry_t struct {op1, op2, dr, we, ctrl}.
- Sub-module: scoreboard (busy register, set/clear/clear-all, eb output).
- The bypass mux and the pipeline register stay in operand_fetch.

## Test plan
- Independent issue: bank r3=5, r4=7. Issue sr1=3, sr2=4, dr=5, we. Next cycle: out_op1=5, out_op2=7, out_valid=1, busy[5]=1.
- RAW stall: issue dr=5, then sr1=5. in_ready=0 until wb_en, wb_dr=5, wb_data=0xAB. Accepted in that same cycle with out_op1=0xAB next cycle, busy[5]=0.
- Register 0: issue we, dr=0, then sr1=0 with use1. No stall, busy stays 0, out_op1=0.
- Backpressure: out_ready=0 for 3 cycles with a valid entry. in_ready=0 and the output is stable. Releasing out_ready accepts the next instruction in the same cycle.
- Set/clear collision: wb_dr=6 clears while a new issue with dr=6 is accepted. busy[6]=1 afterwards.
- Flush and reset: with busy=0x60 and out_valid=1, assert flush. Next cycle busy=0, out_valid=0. Reset mid-stall gives all outputs 0 and in_ready=0.
